// File: rtl/muldiv_unit.sv
// RV32M multiply/divide responder: one request in flight, a registered product for multiplies,
// and a 32-step radix-2 restoring divider for divides and remainders.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    localparam int              CNT_W   = $clog2(DIV_CYCLES);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] result_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;

    // ---------------- request decode ----------------
    logic            accept;
    logic            req_signed;
    logic            req_div_zero;
    logic            req_overflow;
    logic            req_special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    assign accept       = req_valid && req_ready;
    assign req_signed   = !req_op[0];
    assign req_div_zero = (req_b == '0);
    assign req_overflow = req_signed && (req_a == MIN_NEG) && (req_b == '1);
    assign req_special  = req_div_zero || req_overflow;
    assign abs_a        = (req_signed && req_a[XLEN-1]) ? -req_a : req_a;
    assign abs_b        = (req_signed && req_b[XLEN-1]) ? -req_b : req_b;
    // Divide-by-zero: quotient all ones, remainder is the dividend. Overflow: quotient MIN_NEG, remainder 0.
    assign special_res  = req_div_zero ? (req_op[1] ? req_a : '1)
                                       : (req_op[1] ? '0 : MIN_NEG);

    // ---------------- multiplier ----------------
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign a_sext    = (op_q != 2'b11) && a_q[XLEN-1];
    assign b_sext    = !op_q[1] && b_q[XLEN-1];
    assign mul_a_ext = {{XLEN{a_sext}}, a_q};
    assign mul_b_ext = {{XLEN{b_sext}}, b_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;
    assign mul_res   = (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // ---------------- divider step ----------------
    logic [XLEN:0]   rem_shift, diff;
    logic            no_borrow;
    logic [XLEN-1:0] rem_next, quo_next, rem_fix, quo_fix, div_res;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    // A set top bit of the shifted remainder already exceeds any divisor; otherwise diff's top bit is the borrow.
    assign no_borrow = rem_shift[XLEN] | ~diff[XLEN];
    assign rem_next  = no_borrow ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_next  = {quo_q[XLEN-2:0], no_borrow};
    assign quo_fix   = neg_quo_q ? -quo_next : quo_next;
    assign rem_fix   = neg_rem_q ? -rem_next : rem_next;
    assign div_res   = op_q[1] ? rem_fix : quo_fix;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_op[2])      state_d = ST_MUL;
                        else if (req_special) state_d = ST_DONE;
                        else                 state_d = ST_DIV;
                    end
                end
                ST_MUL:  state_d = ST_DONE;
                ST_DIV:  if (cnt_q == '0) state_d = ST_DONE;
                ST_DONE: if (resp_valid_q && resp_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !flush;
        resp_valid = resp_valid_q;
        resp_data  = resp_data_q;
    end

    // ---------------- operand and divider datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= req_op[1:0];
            a_q       <= req_a;
            b_q       <= req_b;
            rem_q     <= '0;
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            cnt_q     <= CNT_W'(DIV_CYCLES - 1);
            neg_quo_q <= req_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
            neg_rem_q <= req_signed && req_a[XLEN-1];
            if (req_op[2] && req_special) begin
                result_q <= special_res;
            end
        end else if (state_q == ST_MUL) begin
            result_q <= mul_res;
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                result_q <= div_res;
            end
        end
    end

    // ---------------- response register ----------------
    // The result is copied to resp_data on the first DONE cycle, so it only changes at a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else if (flush) begin
            resp_valid_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            if (!resp_valid_q) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= result_q;
            end else if (resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit: a scoreboard queue carries the expected result
// and latency of each request, checked when the response appears.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    typedef struct {
        logic [31:0] data;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    muldiv_unit #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Independent reference: 64-bit products and native SV division.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, p;
        logic        ovf;
        ax  = (op != OP_MULHU) ? {{32{a[31]}}, a} : {32'b0, a};
        bx  = (op == OP_MUL || op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ax * bx;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:  return p[31:0];
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            OP_REMU: return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one request at a falling edge; returns just after the accepting edge N.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string tag);
        @(negedge clk);
        check_bit({tag, " req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        exp_q.push_back('{data: exp, lat: lat, tag: tag});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // k = number of edges after N until resp_valid is seen, sampled on falling edges.
    task automatic wait_resp(output int k);
        k = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic compare_head();
        int   k;
        exp_t e;
        wait_resp(k);
        e = exp_q.pop_front();
        check({e.tag, " latency"}, 32'(k), 32'(e.lat));
        check({e.tag, " data"}, resp_data, e.data);
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check_bit({tag, " resp_valid cleared"}, resp_valid, 1'b0);
        check_bit({tag, " req_ready after"}, req_ready, 1'b1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        issue(op, a, b, exp, lat, tag);
        compare_head();
        handshake(tag);
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] ra, rb, held;
        logic [2:0]  rop;
        logic        seen;

        rstn       = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;

        #12;
        check_bit("reset resp_valid", resp_valid, 1'b0);
        check("reset resp_data", resp_data, 32'h0);
        check_bit("reset req_ready", req_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Multiplies.
        run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul_7x-3");
        run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh_min");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu_max");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2, "mulhsu_-1x2");

        // Iterative divides.
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_-7/2");
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_-7/2");
        run_op(OP_DIVU, 32'd100,       32'd7, 32'd14,        33, "divu_100/7");
        run_op(OP_REMU, 32'd100,       32'd7, 32'd2,         33, "remu_100/7");

        // Special cases resolved at accept.
        run_op(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run_op(OP_REMU, 32'd5,         32'd0,         32'd5,         1, "remu_by0");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem_ovf");
        run_op(OP_REM,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1, "rem_by0");

        // Randomized mix against the reference model.
        pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_1234};
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom();
            rb  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom();
            run_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb), $sformatf("rand%0d", i));
        end

        // Backpressure: response held for 5 cycles with a new request waiting.
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 2, "bp_mul");
        compare_head();
        held      = 32'd15;
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd9;
        req_b     = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit($sformatf("bp%0d resp_valid", i), resp_valid, 1'b1);
            check($sformatf("bp%0d resp_data", i), resp_data, held);
            check_bit($sformatf("bp%0d req_ready", i), req_ready, 1'b0);
        end
        req_valid = 1'b0;
        handshake("bp");
        check("bp resp_data kept", resp_data, held);

        // Flush at divider iteration 10.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check_bit("flush req_ready low", req_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_bit("flush req_ready after", req_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check_bit("flush no response", seen, 1'b0);
        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, "post_flush");

        // Reset pulse while a multiply is in the MUL state.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'd6;
        req_b     = 32'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_bit("rst mid-mul req_ready", req_ready, 1'b1);
        check_bit("rst mid-mul resp_valid", resp_valid, 1'b0);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        check_bit("rst mid-mul no response", seen, 1'b0);

        // Reset pulse while a response is pending: outputs drop without waiting for a clock.
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 2, "rst_pending");
        compare_head();
        #2 rstn = 1'b0;
        #1;
        check_bit("rst pending resp_valid", resp_valid, 1'b0);
        check("rst pending resp_data", resp_data, 32'h0);
        @(posedge clk);
        #2 rstn = 1'b1;

        run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
